bim_ctr_table: RTL and testbench



---
 rtl/bim_pkg.sv | 31 +++
 rtl/bim_ctr_sram.sv | 35 +++
 rtl/bim_ctr_table.sv | 166 ++++++++++++++++
 tb/tb_bim_ctr_table.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bim_pkg.sv
// Shared types and counter arithmetic for the bimodal counter table.
package bim_pkg;

  // Widest counter supported; ctr_t carries a single counter zero-extended to this width.
  localparam int unsigned CtrMaxBits = 8;

  typedef logic [CtrMaxBits-1:0] ctr_t;

  typedef enum logic {
    StInit,
    StReady
  } bim_state_e;

  // Saturation ceiling for a counter of the given width.
  function automatic ctr_t ctr_max(input int unsigned bits);
    return ctr_t'((1 << bits) - 1);
  endfunction

  // Saturating step towards the resolved direction.
  function automatic ctr_t ctr_sat_update(input ctr_t old, input logic taken, input ctr_t max_val);
    ctr_t res;
    res = old;
    if (taken) begin
      if (old != max_val) res = old + ctr_t'(1);
    end else begin
      if (old != '0) res = old - ctr_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bim_ctr_sram.sv
// Behavioural SETS x (WAYS*CTR_BITS) 1R1W array with per-lane write mask.
// Read is read-first: a same-edge write is not visible in the returned row.
module bim_ctr_sram #(
  parameter int unsigned SETS     = 2048,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned CTR_BITS = 2,
  localparam int unsigned IDX_W   = $clog2(SETS),
  localparam int unsigned ROW_W   = WAYS * CTR_BITS
) (
  input  logic             clock,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [ROW_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WAYS-1:0]  wr_mask,
  input  logic [ROW_W-1:0] wr_data
);

  logic [ROW_W-1:0] mem_q [SETS];
  logic [ROW_W-1:0] rd_data_q;

  // Storage and registered read data; contents need no reset since the sweep initialises them.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
    if (wr_en) begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (wr_mask[i]) mem_q[wr_addr][i*CTR_BITS +: CTR_BITS] <= wr_data[i*CTR_BITS +: CTR_BITS];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bim_ctr_table.sv
// Bimodal predictor counter table: init sweep, saturating lane-masked update,
// 1-cycle read with optional write-to-read bypass.
module bim_ctr_table
  import bim_pkg::*;
#(
  parameter int unsigned SETS     = 2048,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned INIT_VAL = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned IDX_W   = $clog2(SETS),
  localparam int unsigned ROW_W   = WAYS * CTR_BITS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  output logic             ready,
  input  logic             rd_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_resp_valid,
  output logic [ROW_W-1:0] rd_resp_ctrs,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [WAYS-1:0]  upd_mask,
  input  logic [WAYS-1:0]  upd_taken,
  input  logic [ROW_W-1:0] upd_old_ctrs
);

  localparam ctr_t                CTR_MAX  = ctr_max(CTR_BITS);
  localparam logic [CTR_BITS-1:0] INIT_CTR = CTR_BITS'(INIT_VAL);
  localparam logic [IDX_W-1:0]    LAST_ROW = IDX_W'(SETS - 1);

  bim_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             rd_acc, upd_acc, sweep_we;
  logic [ROW_W-1:0] upd_new;

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WAYS-1:0]  wr_mask;
  logic [ROW_W-1:0] wr_data;
  logic [ROW_W-1:0] sram_rd_data;

  logic             resp_valid_q, resp_valid_d;
  logic             byp_hit_q, byp_hit_d;
  logic [WAYS-1:0]  byp_mask_q, byp_mask_d;
  logic [ROW_W-1:0] byp_data_q, byp_data_d;
  logic [ROW_W-1:0] resp_hold_q, resp_hold_d;
  logic [ROW_W-1:0] resp_merged;

  assign ready = (state_q == StReady);

  // A flush in the same cycle drops any request.
  assign rd_acc   = rd_valid & ready & ~flush;
  assign upd_acc  = upd_valid & ready & ~flush;
  assign sweep_we = (state_q == StInit) & ~flush;

  // Sweep FSM next state: one row per cycle, flush restarts from row 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        if (flush) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == LAST_ROW) state_d = StReady;
        end
      end
      StReady: begin
        if (flush) begin
          state_d = StInit;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        ptr_d   = '0;
      end
    endcase
  end

  // Per-lane saturating arithmetic on the requester-supplied old counters.
  always_comb begin
    upd_new = upd_old_ctrs;
    for (int unsigned i = 0; i < WAYS; i++) begin
      upd_new[i*CTR_BITS +: CTR_BITS] = CTR_BITS'(ctr_sat_update(
          ctr_t'(upd_old_ctrs[i*CTR_BITS +: CTR_BITS]), upd_taken[i], CTR_MAX));
    end
  end

  // Write port mux: the sweep owns the port while initialising.
  always_comb begin
    wr_en   = sweep_we | upd_acc;
    wr_addr = upd_idx;
    wr_mask = upd_mask;
    wr_data = upd_new;
    if (sweep_we) begin
      wr_addr = ptr_q;
      wr_mask = '1;
      wr_data = {WAYS{INIT_CTR}};
    end
  end

  bim_ctr_sram #(
    .SETS     (SETS),
    .WAYS     (WAYS),
    .CTR_BITS (CTR_BITS)
  ) u_sram (
    .clock   (clock),
    .rd_en   (rd_acc),
    .rd_addr (rd_idx),
    .rd_data (sram_rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_mask (wr_mask),
    .wr_data (wr_data)
  );

  // Response path: capture same-row update lanes for forwarding, hold last response.
  always_comb begin
    resp_valid_d = rd_acc;
    byp_hit_d    = byp_hit_q;
    byp_mask_d   = byp_mask_q;
    byp_data_d   = byp_data_q;
    if (rd_acc) begin
      byp_hit_d  = (BYPASS != 0) && upd_acc && (rd_idx == upd_idx);
      byp_mask_d = upd_mask;
      byp_data_d = upd_new;
    end
    resp_merged = sram_rd_data;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (byp_hit_q && byp_mask_q[i]) begin
        resp_merged[i*CTR_BITS +: CTR_BITS] = byp_data_q[i*CTR_BITS +: CTR_BITS];
      end
    end
    resp_hold_d = resp_valid_q ? resp_merged : resp_hold_q;
  end

  assign rd_resp_valid = resp_valid_q;
  assign rd_resp_ctrs  = resp_valid_q ? resp_merged : resp_hold_q;

  // State and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      byp_hit_q    <= 1'b0;
      byp_mask_q   <= '0;
      byp_data_q   <= '0;
      resp_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      byp_hit_q    <= byp_hit_d;
      byp_mask_q   <= byp_mask_d;
      byp_data_q   <= byp_data_d;
      resp_hold_q  <= resp_hold_d;
    end
  end

endmodule

// File: tb/tb_bim_ctr_table.sv
// Bench for bim_ctr_table: default geometry with BYPASS=1 and BYPASS=0 sharing stimulus,
// plus a 64x8x3-bit instance.
module tb_bim_ctr_table;

  typedef struct {
    logic [7:0] e;
    logic [7:0] enb;
    int         due;
  } exp_t;

  typedef struct {
    logic [10:0] idx;
    logic [3:0]  mask;
    logic [3:0]  taken;
    logic [7:0]  old;
    logic [7:0]  exp;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, flush, rd_valid, upd_valid;
  logic [10:0] rd_idx, upd_idx;
  logic [3:0]  upd_mask, upd_taken;
  logic [7:0]  upd_old_ctrs;
  logic        ready, rd_resp_valid, nb_ready, nb_resp_valid;
  logic [7:0]  rd_resp_ctrs, nb_resp_ctrs;

  logic        p_flush, p_rd_valid, p_upd_valid, p_ready, p_resp_valid;
  logic [5:0]  p_rd_idx, p_upd_idx;
  logic [7:0]  p_upd_mask, p_upd_taken;
  logic [23:0] p_upd_old, p_resp_ctrs;

  localparam logic [23:0] PINIT = {8{3'd4}};

  exp_t sb[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   p_rise = -1;

  bim_ctr_table dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .ready(ready),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_resp_valid(rd_resp_valid),
    .rd_resp_ctrs(rd_resp_ctrs), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_mask(upd_mask), .upd_taken(upd_taken), .upd_old_ctrs(upd_old_ctrs)
  );

  bim_ctr_table #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .flush(flush), .ready(nb_ready),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_resp_valid(nb_resp_valid),
    .rd_resp_ctrs(nb_resp_ctrs), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_mask(upd_mask), .upd_taken(upd_taken), .upd_old_ctrs(upd_old_ctrs)
  );

  bim_ctr_table #(.SETS(64), .WAYS(8), .CTR_BITS(3), .INIT_VAL(4)) dut_p (
    .clock(clock), .reset_n(reset_n), .flush(p_flush), .ready(p_ready),
    .rd_valid(p_rd_valid), .rd_idx(p_rd_idx), .rd_resp_valid(p_resp_valid),
    .rd_resp_ctrs(p_resp_ctrs), .upd_valid(p_upd_valid), .upd_idx(p_upd_idx),
    .upd_mask(p_upd_mask), .upd_taken(p_upd_taken), .upd_old_ctrs(p_upd_old)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard pop at the negedge: every response must match the oldest due entry.
  task automatic check_resp();
    exp_t x;
    if (rd_resp_valid || nb_resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        check("resp_cycle", cyc, x.due);
        check("resp_valid_pair", {30'd0, rd_resp_valid, nb_resp_valid}, 32'd3);
        check("resp_bypass", {24'd0, rd_resp_ctrs}, {24'd0, x.e});
        check("resp_nobypass", {24'd0, nb_resp_ctrs}, {24'd0, x.enb});
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      check("missing_resp", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_resp();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle();
    flush = 1'b0;
    rd_valid = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [10:0] idx, input logic [7:0] e, input logic [7:0] enb);
    rd_valid = 1'b1;
    rd_idx = idx;
    sb.push_back('{e: e, enb: enb, due: cyc + 1});
  endtask

  task automatic do_upd(input logic [10:0] idx, input logic [3:0] m, input logic [3:0] t,
                        input logic [7:0] o);
    upd_valid = 1'b1;
    upd_idx = idx;
    upd_mask = m;
    upd_taken = t;
    upd_old_ctrs = o;
  endtask

  // Count edges until ready rises, bounded.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!ready && n < 6000) begin
      step();
      n++;
      if (p_ready && p_rise < 0) p_rise = n;
    end
    check(name, n, exp_cycles);
  endtask

  task automatic p_upd(input logic [5:0] idx, input logic [7:0] m, input logic [7:0] t,
                       input logic [23:0] o);
    p_upd_valid = 1'b1;
    p_upd_idx = idx;
    p_upd_mask = m;
    p_upd_taken = t;
    p_upd_old = o;
    step();
    p_upd_valid = 1'b0;
  endtask

  task automatic p_read(input logic [5:0] idx, input logic [23:0] e);
    p_rd_valid = 1'b1;
    p_rd_idx = idx;
    step();
    p_rd_valid = 1'b0;
    @(negedge clock);
    check("p_resp_valid", {31'd0, p_resp_valid}, 32'd1);
    check("p_resp_ctrs", {8'd0, p_resp_ctrs}, {8'd0, e});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // {idx, mask, taken, old, expected row after update}
    vecs[0] = '{11'd5,    4'hF,    4'b1010, 8'h55, 8'h88};
    vecs[1] = '{11'd6,    4'hF,    4'hF,    8'hFF, 8'hFF};
    vecs[2] = '{11'd7,    4'hF,    4'h0,    8'h00, 8'h00};
    vecs[3] = '{11'd8,    4'b0100, 4'hF,    8'h55, 8'h65};
    vecs[4] = '{11'd10,   4'h0,    4'h0,    8'h00, 8'h55};
    vecs[5] = '{11'd11,   4'hF,    4'hF,    8'h1B, 8'h6F};
    vecs[6] = '{11'd2047, 4'b1000, 4'h0,    8'h55, 8'h15};
    vecs[7] = '{11'd0,    4'b0011, 4'b0001, 8'hFE, 8'h5B};

    reset_n = 1'b0;
    idle();
    rd_idx = '0; upd_idx = '0; upd_mask = '0; upd_taken = '0; upd_old_ctrs = '0;
    p_flush = 1'b0; p_rd_valid = 1'b0; p_upd_valid = 1'b0;
    p_rd_idx = '0; p_upd_idx = '0; p_upd_mask = '0; p_upd_taken = '0; p_upd_old = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    check("rst_resp_ctrs", {24'd0, rd_resp_ctrs}, 32'd0);
    check("rst_nb_ready", {31'd0, nb_ready}, 32'd0);
    check("rst_p_ready", {31'd0, p_ready}, 32'd0);
    check("rst_p_ctrs", {8'd0, p_resp_ctrs}, 32'd0);

    reset_n = 1'b1;
    wait_ready("ready_rise", 2048);
    check("p_ready_rise", p_rise, 64);

    do_read(11'd0, 8'h55, 8'h55);    step();
    do_read(11'd1023, 8'h55, 8'h55); step();
    do_read(11'd2047, 8'h55, 8'h55); step();
    idle(); step(); step();
    check("hold_valid", {31'd0, rd_resp_valid}, 32'd0);
    check("hold_ctrs", {24'd0, rd_resp_ctrs}, 32'h55);

    for (int i = 0; i < 8; i++) begin
      do_upd(vecs[i].idx, vecs[i].mask, vecs[i].taken, vecs[i].old);
      step();
      idle();
      do_read(vecs[i].idx, vecs[i].exp, vecs[i].exp);
      step();
      idle();
      step();
    end

    // Same-row read+update: bypass forwards, no-bypass shows old row, both see new next read.
    do_upd(11'd9, 4'b0001, 4'b0001, 8'h55);
    do_read(11'd9, 8'h56, 8'h55);
    step();
    idle();
    do_read(11'd9, 8'h56, 8'h56);
    step();
    // Different rows in the same cycle must not forward.
    do_upd(11'd12, 4'hF, 4'hF, 8'h55);
    do_read(11'd13, 8'h55, 8'h55);
    step();
    idle();
    do_read(11'd12, 8'hAA, 8'hAA);
    step();
    idle(); step(); step();

    // Flush from READY, with requests in the flush cycle and during the sweep.
    do_upd(11'd3, 4'hF, 4'hF, 8'h55);
    step();
    idle();
    do_read(11'd3, 8'hAA, 8'hAA);
    step();
    idle(); step();
    flush = 1'b1;
    rd_valid = 1'b1; rd_idx = 11'd3;
    upd_valid = 1'b1; upd_idx = 11'd3; upd_mask = 4'hF; upd_taken = 4'h0; upd_old_ctrs = 8'h55;
    step();
    idle();
    check("flush_ready_drop", {31'd0, ready}, 32'd0);
    rd_valid = 1'b1; rd_idx = 11'd4;
    wait_ready("flush_sweep", 2048);
    idle();
    do_read(11'd3, 8'h55, 8'h55);
    step();
    idle(); step(); step();

    // Flush again, then restart the sweep from inside INIT.
    flush = 1'b1;
    step();
    idle();
    repeat (100) step();
    flush = 1'b1;
    step();
    idle();
    wait_ready("init_flush_restart", 2048);

    // Asynchronous reset mid-traffic, then again mid-sweep at row 700.
    reset_n = 1'b0;
    #1;
    check("rst_async_ready", {31'd0, ready}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    repeat (700) step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    wait_ready("rst_mid_sweep", 2048);
    do_read(11'd5, 8'h55, 8'h55); step();
    do_read(11'd3, 8'h55, 8'h55); step();
    idle(); step(); step();

    // Alternate geometry: 64 rows, 8 lanes of 3-bit counters, init 4.
    check("p_ready_now", {31'd0, p_ready}, 32'd1);
    p_read(6'd0, PINIT);
    p_read(6'd31, PINIT);
    p_read(6'd63, PINIT);
    p_upd(6'd5, 8'hFF, 8'hAA, PINIT);
    p_read(6'd5, {4{3'd5, 3'd3}});
    p_upd(6'd6, 8'hFF, 8'hFF, 24'hFFFFFF);
    p_read(6'd6, 24'hFFFFFF);
    p_upd(6'd7, 8'hFF, 8'h00, 24'h000000);
    p_read(6'd7, 24'h000000);
    p_upd(6'd8, 8'h04, 8'hFF, PINIT);
    p_read(6'd8, {{5{3'd4}}, 3'd5, {2{3'd4}}});

    step(); step();
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
